// File: rtl/pipeline_hazard_ctrl.sv
// Central stall/flush controller for the 5-stage pipeline: arbitrates memory waits,
// taken-branch flushes and load-use bubbles, with a memory watchdog and stall counter.
module pipeline_hazard_ctrl #(
  parameter int REG_W       = 5,
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rt,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             ex_MemtoReg,
  input  logic             ex_branch_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_en,
  output logic             en_IF_ID,
  output logic             en_ID_EX,
  output logic             en_EX_MEM,
  output logic             en_MEM_WB,
  output logic             flush_IF_ID,
  output logic             flush_ID_EX,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_count
);

  localparam int WC_W = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERROR    = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WC_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic             timeout_q, timeout_d;

  logic             luh;
  logic             use_hazard_rules;
  logic             stall_all;

  // Register 0 is hardwired zero, so a load "writing" it never creates a dependency.
  assign luh = ex_MemtoReg && (ex_rd != '0) &&
               ((ex_rd == id_rs) || (id_uses_rt && (ex_rd == id_rt)));

  always_comb begin
    state_d          = state_q;
    wait_cnt_d       = wait_cnt_q;
    timeout_d        = timeout_q;
    use_hazard_rules = 1'b0;
    stall_all        = 1'b0;

    unique case (state_q)
      RUN: begin
        if (mem_req && !mem_ready) begin
          stall_all  = 1'b1;
          state_d    = MEM_WAIT;
          wait_cnt_d = WC_W'(1);
        end else begin
          use_hazard_rules = 1'b1;
        end
      end
      MEM_WAIT: begin
        if (!mem_ready) begin
          stall_all = 1'b1;
          if (wait_cnt_q == WC_W'(MEM_TIMEOUT)) begin
            state_d   = ERROR;
            timeout_d = 1'b1;
          end else begin
            wait_cnt_d = wait_cnt_q + WC_W'(1);
          end
        end else begin
          // The access completes this cycle, so a new request cannot re-stall yet.
          use_hazard_rules = 1'b1;
          state_d          = RUN;
          wait_cnt_d       = '0;
        end
      end
      ERROR: begin
        stall_all = 1'b1;
      end
      default: begin
        stall_all = 1'b1;
        state_d   = RUN;
        wait_cnt_d = '0;
      end
    endcase
  end

  always_comb begin
    pc_en       = 1'b1;
    en_IF_ID    = 1'b1;
    en_ID_EX    = 1'b1;
    en_EX_MEM   = 1'b1;
    en_MEM_WB   = 1'b1;
    flush_IF_ID = 1'b0;
    flush_ID_EX = 1'b0;

    if (stall_all) begin
      pc_en     = 1'b0;
      en_IF_ID  = 1'b0;
      en_ID_EX  = 1'b0;
      en_EX_MEM = 1'b0;
      en_MEM_WB = 1'b0;
    end else if (use_hazard_rules) begin
      if (ex_branch_taken) begin
        // A taken branch squashes the ID instruction, so any load-use on it is moot.
        flush_IF_ID = 1'b1;
        flush_ID_EX = 1'b1;
      end else if (luh) begin
        pc_en       = 1'b0;
        en_IF_ID    = 1'b0;
        flush_ID_EX = 1'b1;
      end
    end

    // The reset input overrides combinationally so the pipeline is never frozen in reset.
    if (!reset) begin
      pc_en       = 1'b1;
      en_IF_ID    = 1'b1;
      en_ID_EX    = 1'b1;
      en_EX_MEM   = 1'b1;
      en_MEM_WB   = 1'b1;
      flush_IF_ID = 1'b0;
      flush_ID_EX = 1'b0;
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (!pc_en && (state_q != ERROR) && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= RUN;
      wait_cnt_q  <= '0;
      stall_cnt_q <= '0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      timeout_q   <= timeout_d;
    end
  end

  assign mem_timeout = timeout_q;
  assign stall_count = stall_cnt_q;

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Central stall/flush controller for the 5-stage pipeline.
- Drives the `en` inputs of IF_ID, ID_EX, EX_MEM and MEM_WB, the PC enable, and bubble (flush) requests.
- Arbitrates between three events: multi-cycle data-memory waits, taken-branch flushes and load-use hazards.
- Also keeps a watchdog on memory latency and a saturating stall counter.

Parameters:
REG_W, 5, register-index width
MEM_TIMEOUT, 15, max cycles in MEM_WAIT before error (>=1)
CNT_W, 16, stall counter width

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
id_rs  in  REG_W  rs of instruction in ID
id_rt  in  REG_W  rt of instruction in ID
id_uses_rt  in  1  ID instruction reads rt
ex_rd  in  REG_W  destination of instruction in EX
ex_MemtoReg  in  1  EX instruction is a load
ex_branch_taken  in  1  branch in EX resolved taken
mem_req  in  1  MEM-stage instruction accesses data memory
mem_ready  in  1  data memory completes access this cycle
pc_en  out  1  PC update enable
en_IF_ID  out  1  IF_ID enable
en_ID_EX  out  1  ID_EX enable
en_EX_MEM  out  1  EX_MEM enable
en_MEM_WB  out  1  MEM_WB enable
flush_IF_ID  out  1  load bubble (all-zero) into IF_ID next edge
flush_ID_EX  out  1  load bubble into ID_EX next edge
mem_timeout  out  1  sticky memory watchdog error
stall_count  out  CNT_W  cycles with pc_en=0, saturating

Behaviour:
- Registered state: fsm ∈ {RUN, MEM_WAIT, ERROR}, wait_cnt (clog2(MEM_TIMEOUT+1) bits), stall_count, mem_timeout.
- Outputs are combinational from state and inputs (Mealy). Hazards act in the same cycle they appear.
- Reset low, asynchronous:
  - fsm=RUN, wait_cnt=0, stall_count=0, mem_timeout=0.
  - While reset is low, all enables=1 and flushes=0, regardless of inputs.
- Load-use hazard (luh) = ex_MemtoReg && ex_rd!=0 && (ex_rd==id_rs || (id_uses_rt && ex_rd==id_rt)).
- RUN, evaluated in priority order:
  1. mem_req && !mem_ready:
     - All five enables=0, flushes=0.
     - Next state MEM_WAIT, wait_cnt<=1.
  2. else ex_branch_taken:
     - All enables=1, flush_IF_ID=1, flush_ID_EX=1.
     - Branch overrides luh; the wrong-path ID instruction is discarded.
  3. else luh:
     - pc_en=0, en_IF_ID=0, en_ID_EX=1, flush_ID_EX=1, en_EX_MEM=1, en_MEM_WB=1.
     - Exactly one bubble; the hazard clears next cycle because ID_EX holds the bubble.
  4. else all enables=1, flushes=0.
- MEM_WAIT:
  - mem_ready=0:
    - All enables=0, flushes=0.
    - wait_cnt<=wait_cnt+1.
    - If wait_cnt==MEM_TIMEOUT, next state ERROR and mem_timeout<=1.
  - mem_ready=1:
    - Outputs follow RUN rules 2–4; rule 1 is ignored for this cycle.
    - Next state RUN, wait_cnt<=0.
  - A branch held in EX during the wait takes effect on the ready cycle.
- ERROR:
  - All enables=0, flushes=0, mem_timeout=1.
  - Stays in ERROR until reset; all inputs are ignored.
- stall_count increments by 1 on each edge where pc_en=0 and fsm!=ERROR, not in reset. It saturates at 2^CNT_W−1 and never wraps.
- Flushes are never asserted in a cycle whose matching enable is 0.
- The pipeline registers give a flush priority over their stored data, but below reset.
- Reset asserted mid-MEM_WAIT: immediate return to RUN values, no timeout flagged.

Test Plan:
- Load-use:
  - Stimulus: ex_MemtoReg=1, ex_rd=5, id_rs=5.
  - Response: that cycle pc_en=0, en_IF_ID=0, flush_ID_EX=1, en_EX_MEM=1. stall_count 0→1. The next cycle, with ex_MemtoReg=0, has all enables=1.
- No false hazard:
  - Case A: ex_rd=0, id_rs=0, ex_MemtoReg=1 → no stall.
  - Case B: ex_rd=7, id_rt=7, id_uses_rt=0 → no stall.
- Branch vs load-use:
  - Stimulus: ex_branch_taken=1 and luh=1 in the same cycle.
  - Response: all enables=1, flush_IF_ID=1, flush_ID_EX=1, stall_count unchanged.
- Memory wait:
  - Stimulus: mem_req=1, with mem_ready=0 for 3 cycles, then 1.
  - Response: all enables=0 for 3 cycles, stall_count=3. On the ready cycle all enables=1 and fsm returns to RUN.
- Timeout:
  - Stimulus: mem_req=1, mem_ready held 0 with MEM_TIMEOUT=15.
  - Response: mem_timeout=1 after 16 stalled cycles; enables stay 0; stall_count frozen at 16. A later mem_ready=1 has no effect.
- Async reset mid-wait:
  - Stimulus: drop reset in cycle 2 of MEM_WAIT, between edges.
  - Response: enables=1, stall_count=0 and mem_timeout=0 immediately. After release the block operates normally from RUN.
